// File: rtl/mult32_seq_if.sv
// mult32_seq_if
// Groups the request/response signals of the sequential 32x32 multiplier.
//   START  : request, honoured only while the multiplier is idle
//   SIGNED : 1 = two's-complement operands, 0 = unsigned (sampled with START)
//   A, B   : multiplicand / multiplier (sampled with START)
//   BUSY   : operation in flight
//   DONE   : one-cycle pulse, HI/LO valid from this cycle on
//   HI, LO : product bits [63:32] / [31:0]
// master drives requests and observes results; slave is the multiplier.
interface mult32_seq_if;
  logic        START;
  logic        SIGNED;
  logic [31:0] A;
  logic [31:0] B;
  logic        BUSY;
  logic        DONE;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output START, SIGNED, A, B,
    input  BUSY, DONE, HI, LO
  );

  modport slave (
    input  START, SIGNED, A, B,
    output BUSY, DONE, HI, LO
  );
endinterface

// File: rtl/mult32_seq.sv
// mult32_seq
// Multi-cycle 32x32 -> 64-bit shift-add multiplier for the ALU MUL path.
// Signed operands are reduced to magnitudes on entry, multiplied unsigned
// over 32 iterations, and the sign is reapplied in a final FIX cycle.
// Ports:
//   CLK : rising-edge clock
//   RST : asynchronous active-high reset
//   bus : mult32_seq_if.slave (START/SIGNED/A/B in, BUSY/DONE/HI/LO out)
// Latency: START sampled at edge k, DONE high in the cycle after edge k+33.
module mult32_seq (
  input  logic        CLK,
  input  logic        RST,
  mult32_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // Magnitude of a 32-bit operand; 0x80000000 maps to itself and is then
  // treated as unsigned, so the magnitude product always fits in 64 bits.
  function automatic logic [31:0] f_abs(input logic signed [31:0] x,
                                        input logic               take);
    logic [31:0] inv;
    inv = ~x;
    if (take && x[31]) f_abs = inv + 32'd1;
    else               f_abs = x;
  endfunction

  // Two's-complement negation of the 64-bit product (invert plus increment).
  function automatic logic signed [63:0] f_neg64(input logic signed [63:0] p);
    logic [63:0] inv;
    inv = ~p;
    f_neg64 = inv + 64'd1;
  endfunction

  logic [1:0]         r_state;
  logic [4:0]         r_cnt;
  logic [32:0]        r_acc;
  logic               r_neg;
  logic               r_busy;
  logic               r_done;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_mcand;
  logic [31:0]        r_mplier;

  logic               w_start;
  logic [31:0]        w_pp;
  logic [32:0]        w_sum;
  logic signed [63:0] w_prod;
  logic signed [63:0] w_res;

  assign w_start = (r_state == S_IDLE) && bus.START;

  // Partial product: multiplicand gated by the current multiplier LSB.
  // r_acc[32] is always zero after the shift, so adding the full 33-bit
  // accumulator is the same as adding into its low 32 bits with carry out.
  always_comb begin
    w_pp   = r_mcand & {32{r_mplier[0]}};
    w_sum  = r_acc + {1'b0, w_pp};
    w_prod = {r_acc[31:0], r_mplier};
    w_res  = r_neg ? f_neg64(w_prod) : w_prod;
  end

  // Control, accumulator and result registers (cleared by reset)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_neg   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_neg   <= bus.SIGNED & (bus.A[31] ^ bus.B[31]);
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= {1'b0, w_sum[32:1]};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_res[63:32];
          r_lo    <= w_res[31:0];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Operand datapath: loaded on accept, shifted during RUN
  always_ff @(posedge CLK) begin
    if (w_start) begin
      r_mcand  <= f_abs(bus.A, bus.SIGNED);
      r_mplier <= f_abs(bus.B, bus.SIGNED);
    end else if (r_state == S_RUN) begin
      r_mplier <= {w_sum[0], r_mplier[31:1]};
    end
  end

  assign bus.BUSY = r_busy;
  assign bus.DONE = r_done;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

endmodule

// File: tb/tb_mult32_seq.sv
module tb_mult32_seq;
  logic CLK;
  logic RST;
  int   vecs;
  int   miss;

  mult32_seq_if bus();

  mult32_seq dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present a request for exactly one edge (edge k), then drop START.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s);
    bus.SIGNED = s;
    bus.A      = a;
    bus.B      = b;
    bus.START  = 1'b1;
    step();
    bus.START  = 1'b0;
  endtask

  // Called just after edge k. Returns in the DONE cycle (or after a bound).
  // poke > 0 raises a stray START with other operands at that RUN cycle.
  task automatic wait_done(input string tag, input logic [63:0] prev,
                           input logic [63:0] exp, input int poke);
    int cycles;
    int busy_n;
    bit hold_bad;
    bit overlap;
    cycles   = 0;
    busy_n   = 0;
    hold_bad = 1'b0;
    overlap  = 1'b0;
    chk({tag, " busy_after_start"}, {63'd0, bus.BUSY}, 64'd1);
    while (cycles < 40) begin
      if (poke > 0 && cycles == poke) begin
        bus.START = 1'b1;
        bus.A     = 32'd7;
        bus.B     = 32'd9;
      end
      if (poke > 0 && cycles == poke + 4) bus.START = 1'b0;
      step();
      cycles++;
      if (bus.DONE && bus.BUSY) overlap = 1'b1;
      if (bus.DONE) break;
      if (bus.BUSY) busy_n++;
      if ({bus.HI, bus.LO} !== prev) hold_bad = 1'b1;
    end
    chk({tag, " latency"},     64'(cycles), 64'd33);
    chk({tag, " busy_cycles"}, 64'(busy_n + 1), 64'd33);
    chk({tag, " busy_done_overlap"}, {63'd0, overlap}, 64'd0);
    chk({tag, " hold_until_fix"},    {63'd0, hold_bad}, 64'd0);
    chk({tag, " product"}, {bus.HI, bus.LO}, exp);
  endtask

  // One cycle after DONE: the pulse must be gone and the result held.
  task automatic after_done(input string tag, input logic [63:0] exp);
    step();
    chk({tag, " done_pulse_width"}, {63'd0, bus.DONE}, 64'd0);
    chk({tag, " result_held"}, {bus.HI, bus.LO}, exp);
  endtask

  initial begin
    int  dn;
    vecs       = 0;
    miss       = 0;
    RST        = 1'b1;
    bus.START  = 1'b0;
    bus.SIGNED = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    #1;
    chk("reset busy", {63'd0, bus.BUSY}, 64'd0);
    chk("reset done", {63'd0, bus.DONE}, 64'd0);
    chk("reset hilo", {bus.HI, bus.LO}, 64'd0);
    step();
    step();
    #2 RST = 1'b0;
    step();
    chk("idle no start", {62'd0, bus.BUSY, bus.DONE}, 64'd0);

    // Unsigned max
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_done("umax", 64'd0, 64'hFFFFFFFE_00000001, 0);
    after_done("umax", 64'hFFFFFFFE_00000001);

    // Same operands, signed then unsigned
    start_op(32'hFFFFFFFD, 32'h00000007, 1'b1);
    wait_done("s_m3x7", 64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFEB, 0);
    after_done("s_m3x7", 64'hFFFFFFFF_FFFFFFEB);
    start_op(32'hFFFFFFFD, 32'h00000007, 1'b0);
    wait_done("u_m3x7", 64'hFFFFFFFF_FFFFFFEB, 64'h00000006_FFFFFFEB, 0);
    after_done("u_m3x7", 64'h00000006_FFFFFFEB);

    // Signed corners
    start_op(32'h80000000, 32'h80000000, 1'b1);
    wait_done("s_min_sq", 64'h00000006_FFFFFFEB, 64'h40000000_00000000, 0);
    after_done("s_min_sq", 64'h40000000_00000000);
    start_op(32'h00000000, 32'h80000000, 1'b1);
    wait_done("s_zero", 64'h40000000_00000000, 64'd0, 0);
    after_done("s_zero", 64'd0);
    start_op(32'hFFFFFFFE, 32'hFFFFFFFD, 1'b1);
    wait_done("s_neg_neg", 64'd0, 64'd6, 0);
    after_done("s_neg_neg", 64'd6);
    start_op(32'd100, 32'hFFFFFFFF, 1'b1);
    wait_done("s_pos_neg", 64'd6, 64'hFFFFFFFF_FFFFFF9C, 0);
    after_done("s_pos_neg", 64'hFFFFFFFF_FFFFFF9C);

    // Handshake: stray START during RUN ignored, START in DONE cycle accepted
    start_op(32'd5, 32'd6, 1'b0);
    wait_done("hs_5x6", 64'hFFFFFFFF_FFFFFF9C, 64'd30, 10);
    bus.A     = 32'd2;
    bus.B     = 32'd3;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    chk("hs accept done_low", {63'd0, bus.DONE}, 64'd0);
    wait_done("hs_2x3", 64'd30, 64'd6, 0);
    after_done("hs_2x3", 64'd6);

    // Asynchronous reset in RUN iteration 10
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    repeat (9) step();
    #2 RST = 1'b1;
    #1;
    chk("arst busy", {63'd0, bus.BUSY}, 64'd0);
    chk("arst done", {63'd0, bus.DONE}, 64'd0);
    chk("arst hilo", {bus.HI, bus.LO}, 64'd0);
    step();
    #3 RST = 1'b0;
    dn = 0;
    repeat (40) begin
      step();
      if (bus.DONE || bus.BUSY) dn++;
    end
    chk("arst no_done_after", 64'(dn), 64'd0);
    start_op(32'd3, 32'd4, 1'b0);
    wait_done("post_rst_3x4", 64'd0, 64'd12, 0);
    after_done("post_rst_3x4", 64'd12);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
